// File: rtl/l524_clkgate_ctrl.sv
// rtl/l524_clkgate_ctrl.sv - idle-driven clock-enable controller with wake/ready handshake
// Optional gated-cycle statistics counter enabled by L524_CLKGATE_STAT_EN.
module l524_clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        test_mode,
  input  logic        sleep_en_i,
  input  logic        busy_i,
  input  logic        req_i,
`ifdef L524_CLKGATE_STAT_EN
  input  logic        stat_clr_i,
  output logic [31:0] gated_cycles_o,
`endif
  output logic        clk_en_o,
  output logic        ready_o,
  output logic        gated_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IDLE_CNT = 2'd1,
    GATED    = 2'd2,
    WAKE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             idle;
  logic             wake_cause;

  assign idle       = !busy_i && !req_i;
  assign wake_cause = req_i || busy_i || !sleep_en_i || test_mode;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (idle) begin
          state_nxt = IDLE_CNT;
          cnt_nxt   = CNT_ONE;
        end
      end
      IDLE_CNT: begin
        // Activity takes priority over the gate decision.
        if (!idle) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt < IDLE_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end else if (sleep_en_i && !test_mode) begin
          state_nxt = GATED;
          cnt_nxt   = '0;
        end
      end
      GATED: begin
        if (wake_cause) begin
          state_nxt = WAKE;
          cnt_nxt   = '0;
        end
      end
      WAKE: begin
        // Requests here are absorbed; the settle count always runs to completion.
        if (cnt == WAKE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign clk_en_o = (state != GATED) || test_mode;
  assign ready_o  = (state == RUN) || (state == IDLE_CNT);
  assign gated_o  = (state == GATED);

`ifdef L524_CLKGATE_STAT_EN
  logic [31:0] gated_cycles;

  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      gated_cycles <= '0;
    end else if (state == GATED && gated_cycles != 32'hFFFF_FFFF) begin
      gated_cycles <= gated_cycles + 32'd1;
    end
  end

  assign gated_cycles_o = gated_cycles;
`endif

endmodule

// File: tb/tb_l524_clkgate_ctrl.sv
// tb/tb_l524_clkgate_ctrl.sv - self-checking bench for l524_clkgate_ctrl
// Two instances (IDLE=4/WAKE=2 and IDLE=1/WAKE=1) checked against a streak/countdown model.
module tb_l524_clkgate_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       test_mode = 1'b0;
  logic       sleep_en_i = 1'b1;
  logic       busy_i = 1'b0;
  logic       req_i = 1'b0;
  logic [1:0] clk_en;
  logic [1:0] ready;
  logic [1:0] gated;
`ifdef L524_CLKGATE_STAT_EN
  logic        stat_clr_i = 1'b0;
  logic [31:0] gated_cycles0;
  logic [31:0] gated_cycles1;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: consecutive-idle streak, gated flag, wake countdown.
  int m_idle[2] = '{4, 1};
  int m_wake[2] = '{2, 1};
  int m_streak[2];
  int m_wleft[2];
  bit m_gated[2];

  always #5 clk = ~clk;

  l524_clkgate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .test_mode(test_mode), .sleep_en_i(sleep_en_i),
    .busy_i(busy_i), .req_i(req_i),
`ifdef L524_CLKGATE_STAT_EN
    .stat_clr_i(stat_clr_i), .gated_cycles_o(gated_cycles0),
`endif
    .clk_en_o(clk_en[0]), .ready_o(ready[0]), .gated_o(gated[0])
  );

  l524_clkgate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .test_mode(test_mode), .sleep_en_i(sleep_en_i),
    .busy_i(busy_i), .req_i(req_i),
`ifdef L524_CLKGATE_STAT_EN
    .stat_clr_i(stat_clr_i), .gated_cycles_o(gated_cycles1),
`endif
    .clk_en_o(clk_en[1]), .ready_o(ready[1]), .gated_o(gated[1])
  );

  task automatic model_step();
    bit idle;
    idle = !busy_i && !req_i;
    for (int i = 0; i < 2; i++) begin
      if (rst_i) begin
        m_gated[i] = 0; m_wleft[i] = 0; m_streak[i] = 0;
      end else if (m_gated[i]) begin
        if (req_i || busy_i || !sleep_en_i || test_mode) begin
          m_gated[i] = 0; m_wleft[i] = m_wake[i];
        end
      end else if (m_wleft[i] > 0) begin
        m_wleft[i]--;
      end else if (idle && m_streak[i] >= m_idle[i] && sleep_en_i && !test_mode) begin
        m_gated[i] = 1; m_streak[i] = 0;
      end else if (idle) begin
        m_streak[i] = (m_streak[i] + 1 > m_idle[i]) ? m_idle[i] : m_streak[i] + 1;
      end else begin
        m_streak[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (clk_en[i] !== 1'b1 || ready[i] !== 1'b1 || gated[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d got en/rdy/gated=%b%b%b want 110", i, clk_en[i], ready[i], gated[i]);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_idle_gate();
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (e <= 4 && clk_en[0] !== 1'b1) begin
        failures++;
        $display("FAIL idle_gate edge %0d clk_en got %b want 1", e, clk_en[0]);
      end
      if (e == 2) begin
        checks++;
        if (gated[1] !== 1'b1 || clk_en[1] !== 1'b0) begin
          failures++;
          $display("FAIL idle_gate_min edge 2 gated/en got %b%b want 10", gated[1], clk_en[1]);
        end
      end
    end
    checks++;
    if (clk_en[0] !== 1'b0 || gated[0] !== 1'b1 || ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_gate edge 5 en/gated/rdy got %b%b%b want 010", clk_en[0], gated[0], ready[0]);
    end
  endtask

  task automatic test_wake();
    req_i = 1'b1;
    tick();
    checks++;
    if (clk_en[0] !== 1'b1 || ready[0] !== 1'b0 || gated[0] !== 1'b0) begin
      failures++;
      $display("FAIL wake N en/rdy/gated got %b%b%b want 100", clk_en[0], ready[0], gated[0]);
    end
    tick();
    checks++;
    if (ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL wake N+1 ready got %b want 0", ready[0]);
    end
    checks++;
    if (ready[1] !== 1'b1) begin
      failures++;
      $display("FAIL wake_min N+1 ready got %b want 1", ready[1]);
    end
    tick();
    checks++;
    if (ready[0] !== 1'b1 || clk_en[0] !== 1'b1) begin
      failures++;
      $display("FAIL wake N+2 rdy/en got %b%b want 11", ready[0], clk_en[0]);
    end
    req_i = 1'b0;
  endtask

  task automatic test_activity_restart();
    for (int e = 0; e < 3; e++) tick();
    busy_i = 1'b1;
    tick();
    busy_i = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (clk_en[0] !== (e <= 4 ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL restart fresh edge %0d clk_en got %b want %b", e, clk_en[0], (e <= 4 ? 1'b1 : 1'b0));
      end
    end
  endtask

  task automatic test_sleep_disable();
    sleep_en_i = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    for (int e = 0; e < 100; e++) begin
      tick();
      checks++;
      if (clk_en[0] !== 1'b1 || ready[0] !== 1'b1) begin
        failures++;
        $display("FAIL sleep_off cycle %0d en/rdy got %b%b want 11", e, clk_en[0], ready[0]);
      end
    end
    sleep_en_i = 1'b1;
    tick();
    checks++;
    if (gated[0] !== 1'b1 || clk_en[0] !== 1'b0) begin
      failures++;
      $display("FAIL sleep_on gated/en got %b%b want 10", gated[0], clk_en[0]);
    end
  endtask

  task automatic test_test_mode();
    test_mode = 1'b1;
    #1;
    checks++;
    if (clk_en[0] !== 1'b1 || gated[0] !== 1'b1) begin
      failures++;
      $display("FAIL tmode same_cycle en/gated got %b%b want 11", clk_en[0], gated[0]);
    end
    tick();
    checks++;
    if (gated[0] !== 1'b0 || ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL tmode wake gated/rdy got %b%b want 00", gated[0], ready[0]);
    end
    tick();
    tick();
    checks++;
    if (ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL tmode run ready got %b want 1", ready[0]);
    end
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (gated !== 2'b00 || clk_en !== 2'b11) begin
        failures++;
        $display("FAIL tmode no_gate cycle %0d gated=%b en=%b want 00/11", e, gated, clk_en);
      end
    end
    test_mode = 1'b0;
  endtask

  task automatic test_reset_in_wake();
    int n;
    n = 0;
    while (gated[0] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (gated[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_wake reach_gated timeout got %b want 1", gated[0]);
    end
`ifdef L524_CLKGATE_STAT_EN
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    checks++;
    if (gated_cycles0 !== 32'd10) begin
      failures++;
      $display("FAIL stat count got %0d want 10", gated_cycles0);
    end
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    checks++;
    if (gated_cycles0 !== 32'd0) begin
      failures++;
      $display("FAIL stat clear got %0d want 0", gated_cycles0);
    end
`endif
    req_i = 1'b1;
    tick();
    checks++;
    if (ready[0] !== 1'b0 || clk_en[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_wake in_wake rdy/en got %b%b want 01", ready[0], clk_en[0]);
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (clk_en[0] !== 1'b1 || ready[0] !== 1'b1 || gated[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_wake after_rst en/rdy/gated got %b%b%b want 110", clk_en[0], ready[0], gated[0]);
    end
    rst_i = 1'b0;
    req_i = 1'b0;
  endtask

  task automatic test_random();
    bit exp_en, exp_rdy;
    for (int c = 0; c < 3000; c++) begin
      busy_i     = ($urandom % 8) == 0;
      req_i      = ($urandom % 10) == 0;
      sleep_en_i = ($urandom % 16) != 0;
      test_mode  = ($urandom % 40) == 0;
      rst_i      = ($urandom % 300) == 0;
      #1;
      for (int i = 0; i < 2; i++) begin
        exp_en = !m_gated[i] || test_mode;
        checks++;
        if (clk_en[i] !== exp_en) begin
          failures++;
          $display("FAIL rand_comb inst%0d cyc %0d clk_en got %b want %b", i, c, clk_en[i], exp_en);
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        exp_en  = !m_gated[i] || test_mode;
        exp_rdy = !m_gated[i] && m_wleft[i] == 0;
        checks++;
        if (clk_en[i] !== exp_en || ready[i] !== exp_rdy || gated[i] !== m_gated[i]) begin
          failures++;
          $display("FAIL rand inst%0d cyc %0d en/rdy/gated got %b%b%b want %b%b%b",
                   i, c, clk_en[i], ready[i], gated[i], exp_en, exp_rdy, m_gated[i]);
        end
      end
    end
    rst_i = 1'b0;
    test_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_wake();
    test_activity_restart();
    test_sleep_disable();
    test_test_mode();
    test_reset_in_wake();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
